// File: rtl/nic_pkg.sv
// Shared ring packet formats, reserved node ids and small helpers for the nic tap.
package nic_pkg;

  localparam logic [5:0] NIC_BCAST_ID = 6'd63;
  localparam logic [5:0] NIC_EMPTY_ID = 6'd0;

  typedef enum logic [1:0] {
    PT_DATA  = 2'd0,
    PT_RETRY = 2'd1,
    PT_IRQ   = 2'd2,
    PT_CTRL  = 2'd3
  } pkt_typ_t;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    pkt_typ_t    typ;
    logic [3:0]  age;
    logic [31:0] dat;
  } packet_t;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [3:0]  age;
    logic [15:0] vec;
  } ipacket_t;

  // A slot is free only when both ids are zero.
  function automatic logic slot_empty(input logic [5:0] did, input logic [5:0] sid);
    return (did | sid) == NIC_EMPTY_ID;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/nic_tap_fifo.sv
// First-word-fall-through FIFO; head visible combinationally, push/pop take effect next clock.
// Push is accepted when not full, or when full with a simultaneous pop; pop on empty is ignored.
module nic_tap_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  T                       push_dat,
  input  logic                   pop,
  output T                       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nic_tap.sv
// Per-node ring tap: delivers/injects packets, captures retries and interrupts; 1-cycle registered rings.
// Host sides use valid/ready (ready = FIFO/hold not full); NIC_TAP_STATS_EN adds saturating event counters.
module nic_tap
  import nic_pkg::*;
#(
  parameter logic [5:0] ID       = 6'd1,
  parameter int         TX_DEPTH = 4,
  parameter int         RX_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  packet_t  packet_i,
  output packet_t  packet_o,
  input  ipacket_t ipacket_i,
  output ipacket_t ipacket_o,
  input  packet_t  rpacket_i,
  output packet_t  rpacket_o,
  input  logic     tx_valid_i,
  output logic     tx_ready_o,
  input  packet_t  tx_pkt_i,
  output logic     rx_valid_o,
  input  logic     rx_ready_i,
  output packet_t  rx_pkt_o,
  input  logic     itx_valid_i,
  output logic     itx_ready_o,
  input  ipacket_t itx_pkt_i,
  output logic     irq_valid_o,
  input  logic     irq_ack_i,
  output ipacket_t irq_pkt_o,
  output logic     rty_valid_o,
  input  logic     rty_ack_i,
  output packet_t  rty_pkt_o
`ifdef NIC_TAP_STATS_EN
  ,
  output logic [15:0] stat_tx_o,
  output logic [15:0] stat_rx_o,
  output logic [15:0] stat_rty_o,
  output logic [15:0] stat_pass_o
`endif
);

  packet_t  tx_head;
  packet_t  pkt_nxt;
  packet_t  rpkt_nxt;
  ipacket_t ipkt_pass;
  ipacket_t ipkt_nxt;
  ipacket_t itx_hold_pkt;
  logic     itx_held;
  logic     tx_full, tx_empty, rx_full, rx_empty;
  logic     tx_push, rx_pop;
  logic     addressed, deliver, inject, pass_full;
  logic     rty_cap;
  logic     irq_free, i_mine, i_bcast, i_own, irq_cap, i_strip, itx_inj, itx_push;
  logic [$clog2(TX_DEPTH):0] tx_cnt;
  logic [$clog2(RX_DEPTH):0] rx_cnt;
  logic     unused_cnt;

  assign unused_cnt = ^{tx_cnt, rx_cnt};

  assign tx_ready_o = ~tx_full;
  assign tx_push    = tx_valid_i & tx_ready_o;
  assign rx_valid_o = ~rx_empty;
  assign rx_pop     = rx_valid_o & rx_ready_i;

  nic_tap_fifo #(.DEPTH(TX_DEPTH), .T(packet_t)) u_tx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (tx_push),
    .push_dat (tx_pkt_i),
    .pop      (inject),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_cnt)
  );

  nic_tap_fifo #(.DEPTH(RX_DEPTH), .T(packet_t)) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (deliver),
    .push_dat (packet_i),
    .pop      (rx_pop),
    .head_dat (rx_pkt_o),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_cnt)
  );

  // Packet ring: deliver first, then the (possibly freed) slot may take the TX head.
  always_comb begin
    addressed = (packet_i.did == ID);
    deliver   = addressed & (~rx_full | rx_pop);
    pass_full = addressed & ~deliver;
    inject    = (deliver | slot_empty(packet_i.did, packet_i.sid)) & ~tx_empty;
    pkt_nxt   = packet_i;
    if (deliver) pkt_nxt = '0;
    if (inject) begin
      pkt_nxt     = tx_head;
      pkt_nxt.sid = ID;
      pkt_nxt.age = '0;
    end
  end

  // An ack in the same cycle frees the hold, so a new notice can be taken immediately.
  always_comb begin
    rty_cap  = (rpacket_i.did == ID) && (rpacket_i.typ == PT_RETRY) && (~rty_valid_o | rty_ack_i);
    rpkt_nxt = rty_cap ? packet_t'('0) : rpacket_i;
  end

  always_comb begin
    irq_free  = ~irq_valid_o | irq_ack_i;
    i_mine    = (ipacket_i.did == ID);
    i_bcast   = (ipacket_i.did == NIC_BCAST_ID);
    i_own     = i_bcast & (ipacket_i.sid == ID);
    irq_cap   = irq_free & (i_mine | (i_bcast & ~i_own));
    i_strip   = (i_mine & irq_free) | i_own;
    ipkt_pass = i_strip ? ipacket_t'('0) : ipacket_i;
    itx_inj   = itx_held & slot_empty(ipkt_pass.did, ipkt_pass.sid);
    itx_push  = itx_valid_i & itx_ready_o;
    ipkt_nxt  = ipkt_pass;
    if (itx_inj) begin
      ipkt_nxt     = itx_hold_pkt;
      ipkt_nxt.sid = ID;
      ipkt_nxt.age = '0;
    end
  end

  assign itx_ready_o = ~itx_held;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      packet_o     <= '0;
      ipacket_o    <= '0;
      rpacket_o    <= '0;
      rty_valid_o  <= 1'b0;
      rty_pkt_o    <= '0;
      irq_valid_o  <= 1'b0;
      irq_pkt_o    <= '0;
      itx_held     <= 1'b0;
      itx_hold_pkt <= '0;
    end else begin
      packet_o  <= pkt_nxt;
      ipacket_o <= ipkt_nxt;
      rpacket_o <= rpkt_nxt;
      if (rty_cap) begin
        rty_valid_o <= 1'b1;
        rty_pkt_o   <= rpacket_i;
      end else if (rty_ack_i) begin
        rty_valid_o <= 1'b0;
      end
      if (irq_cap) begin
        irq_valid_o <= 1'b1;
        irq_pkt_o   <= ipacket_i;
      end else if (irq_ack_i) begin
        irq_valid_o <= 1'b0;
      end
      if (itx_inj) itx_held <= 1'b0;
      if (itx_push) begin
        itx_held     <= 1'b1;
        itx_hold_pkt <= itx_pkt_i;
      end
    end
  end

`ifdef NIC_TAP_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_tx_o   <= '0;
      stat_rx_o   <= '0;
      stat_rty_o  <= '0;
      stat_pass_o <= '0;
    end else begin
      stat_tx_o   <= sat_inc(stat_tx_o, inject);
      stat_rx_o   <= sat_inc(stat_rx_o, deliver);
      stat_rty_o  <= sat_inc(stat_rty_o, rty_cap);
      stat_pass_o <= sat_inc(stat_pass_o, pass_full);
    end
  end
`endif

endmodule

// File: tb/tb_nic_tap.sv
// Directed bench for nic_tap: queue-based reference model checked every cycle plus literal spot checks.
module tb_nic_tap;
  import nic_pkg::*;

  localparam logic [5:0] ID = 6'd1;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  packet_t  packet_i = '0, packet_o;
  ipacket_t ipacket_i = '0, ipacket_o;
  packet_t  rpacket_i = '0, rpacket_o;
  logic     tx_valid = 1'b0, tx_ready;
  packet_t  tx_pkt = '0;
  logic     rx_valid, rx_ready = 1'b0;
  packet_t  rx_pkt;
  logic     itx_valid = 1'b0, itx_ready;
  ipacket_t itx_pkt = '0;
  logic     irq_valid, irq_ack = 1'b0;
  ipacket_t irq_pkt;
  logic     rty_valid, rty_ack = 1'b0;
  packet_t  rty_pkt;
`ifdef NIC_TAP_STATS_EN
  logic [15:0] stat_tx, stat_rx, stat_rty, stat_pass;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nic_tap #(.ID(ID), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .packet_i    (packet_i),
    .packet_o    (packet_o),
    .ipacket_i   (ipacket_i),
    .ipacket_o   (ipacket_o),
    .rpacket_i   (rpacket_i),
    .rpacket_o   (rpacket_o),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .tx_pkt_i    (tx_pkt),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .rx_pkt_o    (rx_pkt),
    .itx_valid_i (itx_valid),
    .itx_ready_o (itx_ready),
    .itx_pkt_i   (itx_pkt),
    .irq_valid_o (irq_valid),
    .irq_ack_i   (irq_ack),
    .irq_pkt_o   (irq_pkt),
    .rty_valid_o (rty_valid),
    .rty_ack_i   (rty_ack),
    .rty_pkt_o   (rty_pkt)
`ifdef NIC_TAP_STATS_EN
    ,
    .stat_tx_o   (stat_tx),
    .stat_rx_o   (stat_rx),
    .stat_rty_o  (stat_rty),
    .stat_pass_o (stat_pass)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic packet_t mk(input logic [5:0] did, input logic [5:0] sid, input pkt_typ_t t,
                                 input logic [3:0] age, input logic [31:0] dat);
    packet_t p;
    p.did = did; p.sid = sid; p.typ = t; p.age = age; p.dat = dat;
    return p;
  endfunction

  function automatic ipacket_t mki(input logic [5:0] did, input logic [5:0] sid,
                                   input logic [3:0] age, input logic [15:0] vec);
    ipacket_t p;
    p.did = did; p.sid = sid; p.age = age; p.vec = vec;
    return p;
  endfunction

  // Reference model: queues for the FIFOs, plain variables for holds and ring slots.
  packet_t  txq[$];
  packet_t  rxq[$];
  packet_t  m_pkt = '0, m_rpkt = '0, m_rty_p = '0;
  ipacket_t m_ipkt = '0, m_irq_p = '0, m_itx_p = '0;
  bit       m_rty_v = 0, m_irq_v = 0, m_itx_v = 0;
  int       m_stat[4] = '{0, 0, 0, 0};

  function automatic bit is_free(input logic [5:0] did, input logic [5:0] sid);
    return did == 6'd0 && sid == 6'd0;
  endfunction

  task automatic bump(input int k);
    if (m_stat[k] < 65535) m_stat[k]++;
  endtask

  task automatic model_step();
    bit       rx_pop, deliver, tx_acc, itx_acc, ifree;
    packet_t  nxt;
    ipacket_t o;
    rx_pop  = rxq.size() > 0 && rx_ready;
    tx_acc  = tx_valid && txq.size() < 4;
    deliver = packet_i.did == ID && (rxq.size() < 4 || rx_pop);
    nxt = packet_i;
    if (rx_pop) void'(rxq.pop_front());
    if (deliver) begin
      rxq.push_back(packet_i);
      nxt = '0;
      bump(1);
    end else if (packet_i.did == ID) begin
      bump(3);
    end
    if (is_free(nxt.did, nxt.sid) && txq.size() > 0) begin
      nxt = txq.pop_front();
      nxt.sid = ID;
      nxt.age = 4'd0;
      bump(0);
    end
    if (tx_acc) txq.push_back(tx_pkt);
    m_pkt = nxt;

    if (rpacket_i.did == ID && rpacket_i.typ == PT_RETRY && (!m_rty_v || rty_ack)) begin
      m_rty_v = 1; m_rty_p = rpacket_i; m_rpkt = '0;
      bump(2);
    end else begin
      if (rty_ack) m_rty_v = 0;
      m_rpkt = rpacket_i;
    end

    ifree   = !m_irq_v || irq_ack;
    itx_acc = itx_valid && !m_itx_v;
    o = ipacket_i;
    if (irq_ack) m_irq_v = 0;
    if (ipacket_i.did == ID) begin
      if (ifree) begin m_irq_v = 1; m_irq_p = ipacket_i; o = '0; end
    end else if (ipacket_i.did == 6'd63) begin
      if (ipacket_i.sid == ID) o = '0;
      else if (ifree) begin m_irq_v = 1; m_irq_p = ipacket_i; end
    end
    if (m_itx_v && is_free(o.did, o.sid)) begin
      o = m_itx_p; o.sid = ID; o.age = 4'd0;
      m_itx_v = 0;
    end
    if (itx_acc) begin m_itx_v = 1; m_itx_p = itx_pkt; end
    m_ipkt = o;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txq.delete(); rxq.delete();
      m_pkt = '0; m_rpkt = '0; m_ipkt = '0; m_rty_p = '0; m_irq_p = '0; m_itx_p = '0;
      m_rty_v = 0; m_irq_v = 0; m_itx_v = 0;
      m_stat = '{0, 0, 0, 0};
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("packet_o", 64'(packet_o), 64'(m_pkt));
    chk("ipacket_o", 64'(ipacket_o), 64'(m_ipkt));
    chk("rpacket_o", 64'(rpacket_o), 64'(m_rpkt));
    chk("tx_ready_o", 64'(tx_ready), 64'(txq.size() < 4));
    chk("rx_valid_o", 64'(rx_valid), 64'(rxq.size() > 0));
    if (rxq.size() > 0) chk("rx_pkt_o", 64'(rx_pkt), 64'(rxq[0]));
    chk("itx_ready_o", 64'(itx_ready), 64'(!m_itx_v));
    chk("irq_valid_o", 64'(irq_valid), 64'(m_irq_v));
    if (m_irq_v) chk("irq_pkt_o", 64'(irq_pkt), 64'(m_irq_p));
    chk("rty_valid_o", 64'(rty_valid), 64'(m_rty_v));
    if (m_rty_v) chk("rty_pkt_o", 64'(rty_pkt), 64'(m_rty_p));
`ifdef NIC_TAP_STATS_EN
    chk("stat_tx_o", 64'(stat_tx), 64'(m_stat[0]));
    chk("stat_rx_o", 64'(stat_rx), 64'(m_stat[1]));
    chk("stat_rty_o", 64'(stat_rty), 64'(m_stat[2]));
    chk("stat_pass_o", 64'(stat_pass), 64'(m_stat[3]));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_packet_o", 64'(packet_o), 64'd0);
    chk("lit_rst_tx_ready", 64'(tx_ready), 64'd1);
    chk("lit_rst_itx_ready", 64'(itx_ready), 64'd1);
    chk("lit_rst_rx_valid", 64'(rx_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Three host packets onto an idle ring
    tx_valid = 1'b1; tx_pkt = mk(6'd2, 6'd9, PT_DATA, 4'd7, 32'hA0);
    tick();
    tx_pkt = mk(6'd2, 6'd9, PT_DATA, 4'd7, 32'hB0);
    tick();
    chk("lit_inj_a", 64'(packet_o), 64'(mk(6'd2, 6'd1, PT_DATA, 4'd0, 32'hA0)));
    chk("lit_inj_ready", 64'(tx_ready), 64'd1);
    tx_pkt = mk(6'd2, 6'd9, PT_DATA, 4'd7, 32'hC0);
    tick();
    chk("lit_inj_b", 64'(packet_o), 64'(mk(6'd2, 6'd1, PT_DATA, 4'd0, 32'hB0)));
    tx_valid = 1'b0;
    tick();
    chk("lit_inj_c", 64'(packet_o), 64'(mk(6'd2, 6'd1, PT_DATA, 4'd0, 32'hC0)));
    tick();

    // Delivery, then fill RX until a packet has to pass through
    rx_ready = 1'b0;
    packet_i = mk(6'd1, 6'd3, PT_DATA, 4'd2, 32'hD0);
    tick();
    chk("lit_dlv_rx_valid", 64'(rx_valid), 64'd1);
    chk("lit_dlv_slot", 64'(packet_o), 64'd0);
    chk("lit_dlv_rx_pkt", 64'(rx_pkt), 64'(mk(6'd1, 6'd3, PT_DATA, 4'd2, 32'hD0)));
    for (int i = 1; i < 4; i++) begin
      packet_i = mk(6'd1, 6'd3, PT_DATA, 4'd2, 32'hD0 + 32'(i));
      tick();
    end
    packet_i = mk(6'd1, 6'd3, PT_DATA, 4'd2, 32'hD4);
    tick();
    chk("lit_full_pass", 64'(packet_o), 64'(mk(6'd1, 6'd3, PT_DATA, 4'd2, 32'hD4)));
`ifdef NIC_TAP_STATS_EN
    chk("lit_stat_pass", 64'(stat_pass), 64'd1);
`endif
    packet_i = '0;
    rx_ready = 1'b1;
    repeat (4) tick();
    chk("lit_drained", 64'(rx_valid), 64'd0);
    rx_ready = 1'b0;

    // Deliver and inject into the same slot
    packet_i = mk(6'd5, 6'd6, PT_DATA, 4'd1, 32'hF1);
    tx_valid = 1'b1; tx_pkt = mk(6'd3, 6'd0, PT_DATA, 4'd9, 32'hE0);
    tick();
    chk("lit_foreign_pass", 64'(packet_o), 64'(mk(6'd5, 6'd6, PT_DATA, 4'd1, 32'hF1)));
    tx_valid = 1'b0;
    packet_i = mk(6'd1, 6'd4, PT_DATA, 4'd0, 32'hF0);
    tick();
    chk("lit_dual_slot", 64'(packet_o), 64'(mk(6'd3, 6'd1, PT_DATA, 4'd0, 32'hE0)));
    chk("lit_dual_rx", 64'(rx_pkt), 64'(mk(6'd1, 6'd4, PT_DATA, 4'd0, 32'hF0)));
    packet_i = '0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Retry notices
    rpacket_i = mk(6'd1, 6'd7, PT_RETRY, 4'd3, 32'h11);
    tick();
    chk("lit_rty_valid", 64'(rty_valid), 64'd1);
    chk("lit_rty_slot", 64'(rpacket_o), 64'd0);
    rpacket_i = mk(6'd1, 6'd8, PT_RETRY, 4'd3, 32'h22);
    tick();
    chk("lit_rty_pass", 64'(rpacket_o), 64'(mk(6'd1, 6'd8, PT_RETRY, 4'd3, 32'h22)));
    chk("lit_rty_hold", 64'(rty_pkt), 64'(mk(6'd1, 6'd7, PT_RETRY, 4'd3, 32'h11)));
    rpacket_i = '0; rty_ack = 1'b1;
    tick();
    rty_ack = 1'b0;
    chk("lit_rty_acked", 64'(rty_valid), 64'd0);

    // Interrupt ring
    ipacket_i = mki(6'd63, 6'd5, 4'd2, 16'h1111);
    tick();
    chk("lit_bc_cap", 64'(irq_valid), 64'd1);
    chk("lit_bc_pass", 64'(ipacket_o), 64'(mki(6'd63, 6'd5, 4'd2, 16'h1111)));
    ipacket_i = '0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    ipacket_i = mki(6'd63, 6'd1, 4'd2, 16'h2222);
    tick();
    chk("lit_own_strip", 64'(ipacket_o), 64'd0);
    chk("lit_own_nocap", 64'(irq_valid), 64'd0);
    ipacket_i = mki(6'd1, 6'd5, 4'd2, 16'h3333);
    tick();
    chk("lit_uc_cap", 64'(irq_pkt), 64'(mki(6'd1, 6'd5, 4'd2, 16'h3333)));
    chk("lit_uc_strip", 64'(ipacket_o), 64'd0);
    ipacket_i = '0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    itx_valid = 1'b1; itx_pkt = mki(6'd4, 6'd0, 4'd5, 16'h4444);
    tick();
    itx_valid = 1'b0;
    chk("lit_itx_busy", 64'(itx_ready), 64'd0);
    tick();
    chk("lit_itx_inj", 64'(ipacket_o), 64'(mki(6'd4, 6'd1, 4'd0, 16'h4444)));

    // Reset while RX holds two packets and rings carry traffic
    packet_i = mk(6'd1, 6'd2, PT_DATA, 4'd0, 32'h60);
    tick();
    packet_i = mk(6'd1, 6'd2, PT_DATA, 4'd0, 32'h61);
    tick();
    packet_i  = mk(6'd5, 6'd6, PT_DATA, 4'd0, 32'h70);
    rpacket_i = mk(6'd7, 6'd6, PT_DATA, 4'd0, 32'h71);
    ipacket_i = mki(6'd9, 6'd6, 4'd0, 16'h72);
    tick();
    chk("lit_pre_rst_rx", 64'(rx_valid), 64'd1);
    chk("lit_pre_rst_ring", 64'(packet_o), 64'(mk(6'd5, 6'd6, PT_DATA, 4'd0, 32'h70)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_rx_valid", 64'(rx_valid), 64'd0);
    chk("lit_arst_packet_o", 64'(packet_o), 64'd0);
    chk("lit_arst_ipacket_o", 64'(ipacket_o), 64'd0);
    chk("lit_arst_rpacket_o", 64'(rpacket_o), 64'd0);
    packet_i = '0; rpacket_i = '0; ipacket_i = '0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
